// File: rtl/ram_dp_arbiter_pkg.sv
// Shared constants and types for the dual-port RAM arbiter.
// Holds default geometry, requester count and the priority-state encoding.
package ram_arb_pkg;

  localparam int NREQ        = 2;
  localparam int RAM_WIDTH   = 8;
  localparam int RAM_DEPTH   = 16;
  localparam int RAM_ADDRESS = 4;

  // Which requester is preferred when both ask in the same cycle.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  // After a grant the other requester becomes preferred.
  function automatic pri_e pri_after(input logic [NREQ-1:0] gnt);
    return gnt[0] ? PRI1 : PRI0;
  endfunction

endpackage

// File: rtl/ram_dp_arbiter_if.sv
// Client-side bus of the dual-port RAM arbiter: two write requesters and
// two read requesters, with requester i in slice i of the packed vectors.
interface ram_dp_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int WIDTH   = RAM_WIDTH,
  parameter int ADDRESS = RAM_ADDRESS
) ();

  logic [NREQ-1:0]         wr_req;
  logic [NREQ*ADDRESS-1:0] wr_addr;
  logic [NREQ*WIDTH-1:0]   wr_data;
  logic [NREQ-1:0]         wr_gnt;
  logic [NREQ-1:0]         rd_req;
  logic [NREQ*ADDRESS-1:0] rd_addr;
  logic [NREQ-1:0]         rd_gnt;
  logic [NREQ-1:0]         rd_valid;
  logic [WIDTH-1:0]        rd_data;

  // Datapath clients.
  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_gnt, rd_gnt, rd_valid, rd_data
  );

  // The arbiter.
  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_gnt, rd_gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/ram_dp_arbiter_rr_arb2.sv
// Two-way arbiter used once per RAM port. Exposes both the candidate (who
// would win if enabled) and the enabled grant, so the caller can veto a grant
// after looking at the candidate without disturbing the priority state.
// Build option RAM_ARB_FIXED_PRI_EN: requester 0 always wins, no state kept.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] cand,
  output logic [NREQ-1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRI_EN
  // Requester 0 wins every contention; requester 1 can starve.
  always_comb begin
    cand = '0;
    if (req[0])      cand = 2'b01;
    else if (req[1]) cand = 2'b10;
  end
`else
  pri_e pri_reg;

  // A lone requester wins outright; contention is settled by pri_reg.
  always_comb begin
    cand = req;
    if (req == 2'b11) cand = (pri_reg == PRI0) ? 2'b01 : 2'b10;
  end

  // Prefer the other requester after any grant; hold when nothing is granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          pri_reg <= PRI0;
    else if (gnt != '0)  pri_reg <= pri_after(gnt);
  end
`endif

  assign gnt = en ? cand : '0;

endmodule

// File: rtl/ram_dp_sync.sv
// Synchronous dual-port RAM: one write port, one read port with a registered
// read. Only the output register is reset; the storage array is not.
module ram_dp_sync #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDRESS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDRESS-1:0] wr_addr,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               rd_en,
  input  logic [ADDRESS-1:0] rd_addr,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the word presented on the write port.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  // Registered read; reset clears only the output register.
  always_ff @(posedge clock) begin
    if (reset)      data_out <= '0;
    else if (rd_en) data_out <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_dp_arbiter.sv
// Arbiter and sequencer in front of a 16x8 dual-port RAM. Each RAM port is
// shared by two requesters through its own rr_arb2. A read whose address
// matches the write being granted in the same cycle is held back one cycle so
// it returns the freshly written word. Read data comes back one cycle after
// the grant with a per-requester valid strobe, and is zero otherwise.
// Build option RAM_ARB_FIXED_PRI_EN (inside rr_arb2) selects fixed priority.
module ram_dp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH   = RAM_WIDTH,
  parameter int DEPTH   = RAM_DEPTH,
  parameter int ADDRESS = RAM_ADDRESS
) (
  input  logic             clock,
  input  logic             reset,
  ram_dp_arbiter_if.slave  bus
);

  logic [NREQ-1:0]    wr_cand;
  logic [NREQ-1:0]    wr_gnt;
  logic [NREQ-1:0]    rd_cand;
  logic [NREQ-1:0]    rd_gnt;
  logic [ADDRESS-1:0] wr_addr_sel;
  logic [WIDTH-1:0]   wr_data_sel;
  logic [ADDRESS-1:0] rd_addr_sel;
  logic               collision;
  logic [NREQ-1:0]    rd_valid_reg;
  logic [WIDTH-1:0]   ram_data_out;

  // Grants are forced off while reset is asserted.
  rr_arb2 u_wr_arb (
    .clock (clock),
    .reset (reset),
    .req   (bus.wr_req),
    .en    (reset),
    .cand  (wr_cand),
    .gnt   (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clock (clock),
    .reset (reset),
    .req   (bus.rd_req),
    .en    (reset & ~collision),
    .cand  (rd_cand),
    .gnt   (rd_gnt)
  );

  // Select the slices of the candidates; grants are one-hot so a 2:1 mux does.
  always_comb begin
    wr_addr_sel = wr_cand[1] ? bus.wr_addr[ADDRESS +: ADDRESS] : bus.wr_addr[0 +: ADDRESS];
    wr_data_sel = wr_cand[1] ? bus.wr_data[WIDTH +: WIDTH]     : bus.wr_data[0 +: WIDTH];
    rd_addr_sel = rd_cand[1] ? bus.rd_addr[ADDRESS +: ADDRESS] : bus.rd_addr[0 +: ADDRESS];
  end

  // Write-first ordering: stall the read candidate that hits the write address.
  assign collision = (wr_gnt != '0) && (rd_cand != '0) && (wr_addr_sel == rd_addr_sel);

  ram_dp_sync #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDRESS (ADDRESS)
  ) u_ram (
    .clock    (clock),
    .reset    (~reset),
    .wr_en    (wr_gnt != '0),
    .wr_addr  (wr_addr_sel),
    .data_in  (wr_data_sel),
    .rd_en    (rd_gnt != '0),
    .rd_addr  (rd_addr_sel),
    .data_out (ram_data_out)
  );

  // Remember which requester owns the word arriving from the RAM next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_valid_reg <= '0;
    else        rd_valid_reg <= rd_gnt;
  end

  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_gnt   = rd_gnt;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = (rd_valid_reg != '0) ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Self-checking bench for ram_dp_arbiter. A reference model (array memory,
// preferred-requester integers) predicts grants each cycle; expected read
// returns go into a queue that a separate monitor pops when rd_valid shows.
module tb_ram_dp_arbiter;

  localparam int W = 8;
  localparam int A = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ram_dp_arbiter_if #(.WIDTH(W), .ADDRESS(A)) bus ();

  ram_dp_arbiter #(.WIDTH(W), .DEPTH(16), .ADDRESS(A)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Client-side stimulus, packed onto the bus.
  logic [1:0]   w_req;
  logic [A-1:0] w_addr [2];
  logic [W-1:0] w_data [2];
  logic [1:0]   r_req;
  logic [A-1:0] r_addr [2];

  assign bus.wr_req  = w_req;
  assign bus.wr_addr = {w_addr[1], w_addr[0]};
  assign bus.wr_data = {w_data[1], w_data[0]};
  assign bus.rd_req  = r_req;
  assign bus.rd_addr = {r_addr[1], r_addr[0]};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model state.
  logic [W-1:0] mem [16];
  int wr_pref = 0;
  int rd_pref = 0;

  typedef struct {
    int           who;
    logic [W-1:0] data;
    int           cyc;
  } rd_exp_t;

  rd_exp_t q[$];

  function automatic logic [1:0] oh(input int i);
    logic [1:0] r;
    r = 2'b00;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Winner among requesters, -1 when nobody asks.
  function automatic int pick(input logic [1:0] req, input int pref);
    if (req == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRI_EN
      return 0;
`else
      return pref;
`endif
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predict this cycle's grants, compare, then advance the model past the edge.
  task automatic eval(output int wg, output int rg);
    int rc;
    #1;
    wg = pick(w_req, wr_pref);
    rc = pick(r_req, rd_pref);
    rg = rc;
    if (wg >= 0 && rc >= 0 && w_addr[wg] == r_addr[rc]) rg = -1;
    if (!reset) begin
      wg = -1;
      rg = -1;
    end
    chk("wr_gnt", {30'd0, bus.wr_gnt}, {30'd0, oh(wg)});
    chk("rd_gnt", {30'd0, bus.rd_gnt}, {30'd0, oh(rg)});
    if (rg >= 0) begin
      q.push_back('{rg, mem[r_addr[rg]], cyc + 1});
      rd_pref = 1 - rg;
    end
    if (wg >= 0) begin
      mem[w_addr[wg]] = w_data[wg];
      wr_pref = 1 - wg;
    end
  endtask

  task automatic step(output int wg, output int rg);
    eval(wg, rg);
    @(negedge clock);
  endtask

  // Monitor: every read return must match the head of the expected queue.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clock);
      checks++;
      if (bus.rd_valid == 2'b00) begin
        if (bus.rd_data !== '0) begin
          errors++;
          $display("FAIL rd_data_idle: got %h want 00 (cycle %0d)", bus.rd_data, cyc);
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
          errors++;
          $display("FAIL rd_missing: got rd_valid 00 want %b (cycle %0d)", oh(q[0].who), cyc);
          void'(q.pop_front());
        end
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_valid %b data %h want no return (cycle %0d)",
                 bus.rd_valid, bus.rd_data, cyc);
      end else begin
        e = q.pop_front();
        if (bus.rd_valid !== oh(e.who) || bus.rd_data !== e.data || e.cyc != cyc) begin
          errors++;
          $display("FAIL rd_return: got valid %b data %h cycle %0d want valid %b data %h cycle %0d",
                   bus.rd_valid, bus.rd_data, cyc, oh(e.who), e.data, e.cyc);
        end else begin
          $display("read  req%0d data %h cycle %0d", e.who, e.data, cyc);
        end
      end
    end
  end

  initial begin
    int wg, rg;
    int got [4];
    int exp_seq [4];

    w_req = 2'b00;
    r_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_addr[i] = '0;
      w_data[i] = '0;
      r_addr[i] = '0;
    end

    // Reset held with every request high: nothing may be granted or returned.
    #1 reset = 1'b0;
    w_req = 2'b11;
    r_req = 2'b11;
    w_addr[0] = 4'd1; w_addr[1] = 4'd2;
    r_addr[0] = 4'd3; r_addr[1] = 4'd4;
    @(negedge clock);
    repeat (2) begin
      step(wg, rg);
      chk("rst_rd_valid", {30'd0, bus.rd_valid}, 32'd0);
      chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    end

    // Release; both write requesters contend on the very first cycle.
    reset = 1'b1;
    r_req = 2'b00;
    w_req = 2'b11;
    w_addr[0] = 4'd3; w_data[0] = 8'hA0;
    w_addr[1] = 4'd5; w_data[1] = 8'hB0;
`ifdef RAM_ARB_FIXED_PRI_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      step(wg, rg);
      got[i] = wg;
    end
    for (int i = 0; i < 4; i++) chk("rr_seq", got[i], exp_seq[i]);
    $display("write rr sequence %0d %0d %0d %0d", got[0], got[1], got[2], got[3]);

    // Fill: requester 0 writes addr i with data i back-to-back.
    w_req = 2'b01;
    for (int i = 0; i < 16; i++) begin
      w_addr[0] = 4'(i);
      w_data[0] = 8'(i);
      step(wg, rg);
      chk("fill_gnt0", wg, 0);
    end

    // Readback from requester 1.
    w_req = 2'b00;
    r_req = 2'b10;
    for (int i = 0; i < 16; i++) begin
      r_addr[1] = 4'(i);
      step(wg, rg);
      chk("readback_gnt1", rg, 1);
    end

    // Collision: preload addr 7, then write and read addr 7 together.
    r_req = 2'b00;
    w_req = 2'b01; w_addr[0] = 4'd7; w_data[0] = 8'h11;
    step(wg, rg);
    w_req = 2'b10; w_addr[1] = 4'd7; w_data[1] = 8'h22;
    r_req = 2'b01; r_addr[0] = 4'd7;
    step(wg, rg);
    chk("coll_stall", rg, -1);
    w_req = 2'b00;
    step(wg, rg);
    chk("coll_grant", rg, 0);
    chk("coll_model_data", {24'd0, mem[7]}, 32'h22);
    r_req = 2'b00;
    step(wg, rg);

    // Random traffic honouring the hold rule; narrow addresses early on
    // so collisions are frequent.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!w_req[i] && $urandom_range(0, 9) < 6) begin
          w_req[i]  = 1'b1;
          w_addr[i] = (c < 200) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
          w_data[i] = 8'($urandom);
        end
        if (!r_req[i] && $urandom_range(0, 9) < 6) begin
          r_req[i]  = 1'b1;
          r_addr[i] = (c < 200) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        end
      end
      step(wg, rg);
      if (wg >= 0) w_req[wg] = 1'b0;
      if (rg >= 0) r_req[rg] = 1'b0;
    end
    w_req = 2'b00;
    r_req = 2'b00;
    step(wg, rg);
    step(wg, rg);

    // Reset mid-read: move both priorities to requester 1, then reset
    // inside the cycle of a read grant to requester 1.
    w_req = 2'b01; w_addr[0] = 4'd2; w_data[0] = 8'h5A;
    r_req = 2'b01; r_addr[0] = 4'd9;
    step(wg, rg);
    w_req = 2'b00;
    r_req = 2'b10; r_addr[1] = 4'd4;
    eval(wg, rg);
    chk("midrd_gnt1", rg, 1);
    reset = 1'b0;
    q.delete();
    wr_pref = 0;
    rd_pref = 0;
    repeat (3) begin
      @(negedge clock);
      chk("midrd_no_valid", {30'd0, bus.rd_valid}, 32'd0);
    end
    reset = 1'b1;
    w_req = 2'b11; w_addr[0] = 4'd1; w_addr[1] = 4'd2; w_data[0] = 8'h01; w_data[1] = 8'h02;
    r_req = 2'b11; r_addr[0] = 4'd3; r_addr[1] = 4'd4;
    step(wg, rg);
    chk("post_rst_wr_pri0", wg, 0);
    chk("post_rst_rd_pri0", rg, 0);
    w_req = 2'b00;
    r_req = 2'b00;
    step(wg, rg);
    step(wg, rg);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
